// File: rtl/icache_responder_pkg.sv
// rtl/icache_responder_pkg.sv - shared constants, FSM state type and address-split helpers
package icache_responder_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  // Line index: the bits just above the line offset
  function automatic logic [XLEN-1:0] idx_of(input logic [XLEN-1:0] addr,
                                             input int off_bits, input int idx_bits);
    return (addr >> off_bits) & ((XLEN'(1) << idx_bits) - XLEN'(1));
  endfunction

  // Tag: everything above offset and index
  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] addr,
                                             input int off_bits, input int idx_bits);
    return addr >> (off_bits + idx_bits);
  endfunction

  // Word within the line, above the two byte bits
  function automatic logic [XLEN-1:0] word_of(input logic [XLEN-1:0] addr,
                                              input int word_bits);
    return (addr >> 2) & ((XLEN'(1) << word_bits) - XLEN'(1));
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// rtl/icache_responder_if.sv - fetch-side and refill-side signals of the instruction cache
interface icache_responder_if #(
  parameter int LINE_BYTES = 16
) ();
  import icache_responder_pkg::*;

  logic                    fetch_req_i;
  logic [XLEN-1:0]         fetch_addr_i;
  logic                    flush_i;
  logic [ILEN-1:0]         instr_o;
  logic                    hit_o;
  logic                    stall_o;
  logic                    misaligned_o;
  logic                    mem_req_o;
  logic [XLEN-1:0]         mem_addr_o;
  logic                    mem_ready_i;
  logic [LINE_BYTES*8-1:0] mem_data_i;

  // Fetch stage plus instruction memory: drives requests and refill data
  modport master (
    output fetch_req_i, fetch_addr_i, flush_i, mem_ready_i, mem_data_i,
    input  instr_o, hit_o, stall_o, misaligned_o, mem_req_o, mem_addr_o
  );

  // The cache itself
  modport slave (
    input  fetch_req_i, fetch_addr_i, flush_i, mem_ready_i, mem_data_i,
    output instr_o, hit_o, stall_o, misaligned_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/icache_responder_line_array.sv
// rtl/icache_responder_line_array.sv - tag/valid/data storage, one write port, combinational read
module icache_line_array #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16,
  parameter int TAG_BITS   = 26,
  localparam int IDX_BITS  = $clog2(NUM_LINES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    we_i,
  input  logic [IDX_BITS-1:0]     widx_i,
  input  logic [TAG_BITS-1:0]     wtag_i,
  input  logic [LINE_BYTES*8-1:0] wdata_i,
  input  logic [IDX_BITS-1:0]     ridx_i,
  output logic                    rvalid_o,
  output logic [TAG_BITS-1:0]     rtag_o,
  output logic [LINE_BYTES*8-1:0] rdata_o
);

  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
  logic [TAG_BITS-1:0]     tag_d  [NUM_LINES];
  logic [LINE_BYTES*8-1:0] data_q [NUM_LINES];
  logic [LINE_BYTES*8-1:0] data_d [NUM_LINES];

  // Flush clears first so a line written in the same cycle still ends up valid
  always_comb begin
    valid_d = flush_i ? '0 : valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we_i) begin
      valid_d[widx_i] = 1'b1;
      tag_d[widx_i]   = wtag_i;
      data_d[widx_i]  = wdata_i;
    end
  end

  // Storage registers; reset overrides any flush or write
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache with line refill FSM
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic               clk,
  input  logic               rst,
  icache_responder_if.slave  bus
);

  localparam int OFF_BITS  = $clog2(LINE_BYTES);
  localparam int WORD_BITS = $clog2(LINE_BYTES / 4);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = XLEN - OFF_BITS - IDX_BITS;
  localparam int WORDS     = LINE_BYTES / 4;

  icache_state_t           state_q, state_d;
  logic [XLEN-1:0]         addr_q, addr_d;
  logic                    we;
  logic [IDX_BITS-1:0]     rd_idx, wr_idx;
  logic [TAG_BITS-1:0]     lk_tag, wr_tag, rd_tag;
  logic                    rd_valid;
  logic [LINE_BYTES*8-1:0] rd_data;
  logic [ILEN-1:0]         word_sel;
  logic                    misaligned;
  logic                    lookup_hit;

  assign rd_idx     = IDX_BITS'(idx_of(bus.fetch_addr_i, OFF_BITS, IDX_BITS));
  assign lk_tag     = TAG_BITS'(tag_of(bus.fetch_addr_i, OFF_BITS, IDX_BITS));
  assign wr_idx     = IDX_BITS'(idx_of(addr_q, OFF_BITS, IDX_BITS));
  assign wr_tag     = TAG_BITS'(tag_of(addr_q, OFF_BITS, IDX_BITS));
  assign misaligned = |bus.fetch_addr_i[1:0];
  assign lookup_hit = rd_valid && (rd_tag == lk_tag);

  icache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_BYTES (LINE_BYTES),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (bus.flush_i),
    .we_i     (we),
    .widx_i   (wr_idx),
    .wtag_i   (wr_tag),
    .wdata_i  (bus.mem_data_i),
    .ridx_i   (rd_idx),
    .rvalid_o (rd_valid),
    .rtag_o   (rd_tag),
    .rdata_o  (rd_data)
  );

  // Pick the addressed 32-bit word out of the looked-up line
  always_comb begin
    word_sel = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (word_of(bus.fetch_addr_i, WORD_BITS) == XLEN'(w)) begin
        word_sel = rd_data[w*32 +: 32];
      end
    end
  end

  // Lookup in IDLE, refill handshake in REFILL; reset forces every output low
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    we               = 1'b0;
    bus.hit_o        = 1'b0;
    bus.stall_o      = 1'b0;
    bus.instr_o      = '0;
    bus.mem_req_o    = 1'b0;
    bus.mem_addr_o   = '0;
    bus.misaligned_o = bus.fetch_req_i && misaligned;
    case (state_q)
      IDLE: begin
        if (bus.fetch_req_i && !misaligned) begin
          if (bus.flush_i) begin
            bus.stall_o = 1'b1;
          end else if (lookup_hit) begin
            bus.hit_o   = 1'b1;
            bus.instr_o = word_sel;
          end else begin
            bus.stall_o = 1'b1;
            addr_d      = bus.fetch_addr_i & ~XLEN'(LINE_BYTES - 1);
            state_d     = REFILL;
          end
        end
      end
      REFILL: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = addr_q;
        bus.stall_o    = 1'b1;
        if (bus.mem_ready_i) begin
          we      = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    if (rst) begin
      bus.hit_o        = 1'b0;
      bus.stall_o      = 1'b0;
      bus.instr_o      = '0;
      bus.mem_req_o    = 1'b0;
      bus.mem_addr_o   = '0;
      bus.misaligned_o = 1'b0;
    end
  end

  // FSM state and latched refill address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - table-driven cycle vectors plus a latency-counted refill sequence
module tb_icache_responder;

  localparam logic [127:0] LINE_10 = 128'h44332211_DDCCBBAA_00000013_00500093;
  localparam logic [127:0] LINE_50 = 128'h5000000C_50000008_50000004_50000000;
  localparam logic [127:0] LINE_XX = 128'hC0DE000C_C0DE0008_C0DE0004_C0DE0000;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        rdy;
    logic        e_hit;
    logic        e_stall;
    logic        e_mis;
    logic        e_mreq;
    logic [31:0] e_instr;
    logic [31:0] e_maddr;
  } vec_t;

  logic clk;
  logic rst;
  vec_t vecs[$];
  int   n_checks;
  int   n_pass;

  icache_responder_if #(.LINE_BYTES(16)) bus ();

  icache_responder #(
    .NUM_LINES  (4),
    .LINE_BYTES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memory model: the line returned depends only on the requested line address
  always_comb begin
    if (bus.mem_addr_o == 32'h10)      bus.mem_data_i = LINE_10;
    else if (bus.mem_addr_o == 32'h50) bus.mem_data_i = LINE_50;
    else                               bus.mem_data_i = LINE_XX;
  end

  task automatic add(input logic r, input logic q, input logic [31:0] a, input logic f,
                     input logic y, input logic h, input logic s, input logic m,
                     input logic mr, input logic [31:0] ins, input logic [31:0] ma);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.flush = f; v.rdy = y;
    v.e_hit = h; v.e_stall = s; v.e_mis = m; v.e_mreq = mr;
    v.e_instr = ins; v.e_maddr = ma;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic h, input logic s, input logic m,
                       input logic mr, input logic [31:0] ins, input logic [31:0] ma);
    n_checks++;
    if (bus.hit_o === h && bus.stall_o === s && bus.misaligned_o === m &&
        bus.mem_req_o === mr && bus.instr_o === ins && bus.mem_addr_o === ma) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got hit=%b stall=%b mis=%b mreq=%b instr=%h maddr=%h, want hit=%b stall=%b mis=%b mreq=%b instr=%h maddr=%h",
               name, bus.hit_o, bus.stall_o, bus.misaligned_o, bus.mem_req_o, bus.instr_o,
               bus.mem_addr_o, h, s, m, mr, ins, ma);
    end
  endtask

  initial begin
    int stalls;
    int nreq;
    bit got_hit;
    n_checks = 0;
    n_pass   = 0;
    rst              = 1'b1;
    bus.fetch_req_i  = 1'b0;
    bus.fetch_addr_i = '0;
    bus.flush_i      = 1'b0;
    bus.mem_ready_i  = 1'b0;

    //  rst req addr   flush rdy  hit stall mis mreq instr         maddr
    add(1, 1, 32'h10, 0, 0,   0, 0, 0, 0, 32'h0,        32'h0);   // reset state
    add(1, 0, 32'h10, 1, 0,   0, 0, 0, 0, 32'h0,        32'h0);   // rst with flush
    add(0, 1, 32'h10, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);   // cold miss
    add(0, 1, 32'h54, 0, 0,   0, 1, 0, 1, 32'h0,        32'h10);  // address latched
    add(0, 1, 32'h10, 0, 0,   0, 1, 0, 1, 32'h0,        32'h10);
    add(0, 1, 32'h10, 0, 0,   0, 1, 0, 1, 32'h0,        32'h10);
    add(0, 1, 32'h10, 0, 1,   0, 1, 0, 1, 32'h0,        32'h10);  // handshake
    add(0, 1, 32'h10, 0, 0,   1, 0, 0, 0, 32'h00500093, 32'h0);   // re-lookup hits
    add(0, 1, 32'h14, 0, 0,   1, 0, 0, 0, 32'h00000013, 32'h0);
    add(0, 1, 32'h1C, 0, 0,   1, 0, 0, 0, 32'h44332211, 32'h0);   // last word of line
    add(0, 0, 32'h10, 0, 1,   0, 0, 0, 0, 32'h0,        32'h0);   // idle, stray ready
    add(0, 1, 32'h18, 0, 0,   1, 0, 0, 0, 32'hDDCCBBAA, 32'h0);
    add(0, 1, 32'h50, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);   // conflict miss
    add(0, 1, 32'h50, 0, 1,   0, 1, 0, 1, 32'h0,        32'h50);
    add(0, 1, 32'h50, 0, 0,   1, 0, 0, 0, 32'h50000000, 32'h0);
    add(0, 1, 32'h10, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);   // evicted
    add(0, 1, 32'h10, 0, 1,   0, 1, 0, 1, 32'h0,        32'h10);
    add(0, 1, 32'h10, 0, 0,   1, 0, 0, 0, 32'h00500093, 32'h0);
    add(0, 1, 32'h12, 0, 0,   0, 0, 1, 0, 32'h0,        32'h0);   // misaligned
    add(0, 1, 32'h20, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);
    add(0, 1, 32'h20, 0, 1,   0, 1, 0, 1, 32'h0,        32'h20);
    add(0, 1, 32'h24, 0, 0,   1, 0, 0, 0, 32'hC0DE0004, 32'h0);
    add(0, 1, 32'h10, 1, 0,   0, 1, 0, 0, 32'h0,        32'h0);   // flush in IDLE
    add(0, 1, 32'h10, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);   // now a miss
    add(0, 1, 32'h10, 0, 1,   0, 1, 0, 1, 32'h0,        32'h10);
    add(0, 1, 32'h10, 0, 0,   1, 0, 0, 0, 32'h00500093, 32'h0);
    add(0, 1, 32'h20, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);
    add(0, 1, 32'h20, 0, 0,   0, 1, 0, 1, 32'h0,        32'h20);
    add(0, 1, 32'h20, 1, 1,   0, 1, 0, 1, 32'h0,        32'h20);  // flush + fill same cycle
    add(0, 1, 32'h20, 0, 0,   1, 0, 0, 0, 32'hC0DE0000, 32'h0);   // filled line kept
    add(0, 1, 32'h10, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);   // others dropped
    add(0, 1, 32'h10, 0, 1,   0, 1, 0, 1, 32'h0,        32'h10);
    add(0, 1, 32'h10, 0, 0,   1, 0, 0, 0, 32'h00500093, 32'h0);
    add(0, 0, 32'h10, 1, 0,   0, 0, 0, 0, 32'h0,        32'h0);   // flush, no fetch
    add(0, 1, 32'h14, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);
    add(0, 1, 32'h14, 0, 1,   0, 1, 0, 1, 32'h0,        32'h10);
    add(0, 1, 32'h14, 0, 0,   1, 0, 0, 0, 32'h00000013, 32'h0);
    add(0, 1, 32'h20, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);
    add(0, 1, 32'h20, 0, 0,   0, 1, 0, 1, 32'h0,        32'h20);
    add(1, 1, 32'h20, 0, 0,   0, 0, 0, 0, 32'h0,        32'h0);   // reset mid-refill
    add(0, 0, 32'h20, 0, 0,   0, 0, 0, 0, 32'h0,        32'h0);   // refill abandoned
    add(0, 1, 32'h14, 0, 0,   0, 1, 0, 0, 32'h0,        32'h0);   // lines invalid
    add(0, 1, 32'h14, 0, 1,   0, 1, 0, 1, 32'h0,        32'h10);
    add(0, 1, 32'h14, 0, 0,   1, 0, 0, 0, 32'h00000013, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst              = vecs[i].rst;
      bus.fetch_req_i  = vecs[i].req;
      bus.fetch_addr_i = vecs[i].addr;
      bus.flush_i      = vecs[i].flush;
      bus.mem_ready_i  = vecs[i].rdy;
      #2;
      check($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_stall, vecs[i].e_mis,
            vecs[i].e_mreq, vecs[i].e_instr, vecs[i].e_maddr);
    end

    // Miss with a three-cycle memory: stall must last exactly five cycles
    stalls  = 0;
    nreq    = 0;
    got_hit = 1'b0;
    for (int c = 0; c < 50 && !got_hit; c++) begin
      @(negedge clk);
      rst              = 1'b0;
      bus.flush_i      = 1'b0;
      bus.fetch_req_i  = 1'b1;
      bus.fetch_addr_i = 32'h58;
      bus.mem_ready_i  = 1'b0;
      #1;
      if (bus.mem_req_o) begin
        bus.mem_ready_i = (nreq == 3);
        nreq++;
      end
      #1;
      if (bus.hit_o) begin
        got_hit = 1'b1;
        check("latency_hit", 1'b1, 1'b0, 1'b0, 1'b0, 32'h50000008, 32'h0);
      end else if (bus.stall_o) begin
        stalls++;
      end
    end
    n_checks++;
    if (got_hit && stalls == 5) n_pass++;
    else $display("FAIL stall_count: got hit=%b stalls=%0d, want hit=1 stalls=5", got_hit, stalls);

    @(negedge clk);
    bus.fetch_req_i = 1'b0;
    bus.mem_ready_i = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache. It is the responder end of the fetch interface.
- The fetch stage presents a PC each cycle. This block returns the 32-bit instruction on a hit, or asserts a stall while it refills a line from the backing instruction memory over a request/ready line port.
- It sits between the fetch stage and the instruction memory model, and replaces direct byte-array reads.

Parameters:
NUM_LINES, 4, number of cache lines; power of two, at least 2
LINE_BYTES, 16, bytes per line; power of two, at least 4; the refill bus is LINE_BYTES*8 bits wide

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
fetch_req_i  input  1  fetch stage presents a valid PC this cycle
fetch_addr_i  input  XLEN  byte address of the instruction
flush_i  input  1  invalidate all lines (fence.i)
instr_o  output  ILEN  instruction; valid only when hit_o=1
hit_o  output  1  instr_o valid this cycle
stall_o  output  1  fetch must hold its PC
misaligned_o  output  1  fetch_addr_i[1:0] != 0 while fetch_req_i=1
mem_req_o  output  1  line refill request; held until mem_ready_i
mem_addr_o  output  XLEN  line-aligned refill address
mem_ready_i  input  1  mem_data_i valid; handshake completes this cycle
mem_data_i  input  LINE_BYTES*8  refill line, little-endian; byte 0 in bits [7:0]

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Outputs under reset: all valid bits cleared; state IDLE; hit_o=0, stall_o=0, mem_req_o=0, misaligned_o=0, instr_o=0, mem_addr_o=0.
- Reset asserted mid-refill abandons the refill. mem_req_o drops on the next edge; the memory side must tolerate the drop.
- Address split: [1:0] byte, then log2(LINE_BYTES/4) word-offset bits, then log2(NUM_LINES) index bits. The remaining bits are the tag.
- Lookup is combinational in IDLE: hit = fetch_req_i AND valid[idx] AND tag match AND aligned.
- On a hit: hit_o=1, stall_o=0, and instr_o = the selected word of the line, all in the same cycle (0-cycle hit latency).
- No request (fetch_req_i=0): hit_o=0, stall_o=0, no state change.
- Misaligned request: misaligned_o=1, hit_o=0, stall_o=0, instr_o=0, no refill started.
- Miss in IDLE: stall_o=1 in the same cycle; the FSM moves to REFILL.
- REFILL state:
  - mem_req_o=1 and mem_addr_o = {fetch_addr_i tag and index, zero offset}.
  - The address is latched on entry; later changes to fetch_addr_i are ignored.
  - stall_o=1 and hit_o=0.
  - Stays in REFILL while mem_ready_i=0.
- Handshake: on mem_ready_i=1 in REFILL, the line data, tag and valid bit are written and the FSM moves to IDLE.
  - The next cycle re-looks up the held PC and hits.
  - Total miss penalty is memory latency + 2 cycles of stall.
- mem_ready_i outside REFILL is ignored.
- Flush:
  - flush_i in IDLE clears all valid bits at the edge. hit_o is forced to 0 that cycle, and stall_o=1 if fetch_req_i=1.
  - flush_i in REFILL clears all valid bits, but a line written in that same cycle is still set valid.
  - flush_i and rst together: rst wins.
- Conflict: a miss to an occupied index evicts the old line unconditionally. There is no write-back.
- Widths: instr_o is always ILEN=32. A word select beyond the line cannot occur by construction.

Decomposition:
- Into constants_pkg: XLEN, ILEN, BOOT_ADDR (existing), plus a new icache_state_t enum {IDLE, REFILL}.
- Into a local package section: helper functions idx_of(), tag_of() and word_of(), derived from the parameters.
- One sub-module, icache_line_array: tag, valid and data storage with a one-port write and a combinational read. It carries the flush-clear logic.
- The FSM and handshake stay in the top module.

Test Plan (NUM_LINES=4, LINE_BYTES=16, XLEN=32):
- Cold miss:
  - Stimulus: after rst, fetch 0x0000_0010; memory returns the line 0x44332211_DDCCBBAA_00000013_00500093 after 3 cycles.
  - Required response: mem_addr_o=0x10; stall_o high for 5 cycles; then hit_o=1 with instr_o=0x00500093.
- Hit on a resident line: fetch 0x0000_0014 in the next cycle -> hit_o=1 in the same cycle, instr_o=0x00000013, no mem_req_o.
- Conflict eviction: fetch 0x0000_0050 (index 1, tag 1) -> miss with mem_addr_o=0x50. A following fetch of 0x10 misses again.
- Misaligned request: fetch 0x0000_0012 -> misaligned_o=1, hit_o=0, stall_o=0, mem_req_o stays 0.
- Flush:
  - Stimulus: flush_i pulse with line 0x10 resident, then fetch 0x10.
  - Required response: miss/refill. Separately, flush_i during REFILL followed by mem_ready_i leaves that line valid and all others invalid.
- Reset mid-refill: rst asserted while mem_req_o=1 and mem_ready_i=0 -> the next cycle shows mem_req_o=0, stall_o=0 and all lines invalid.
